// File: rtl/add_arbiter_pkg.sv
// rtl/add_arbiter_pkg.sv - shared types and constants for the two-way adder arbiter
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

  // Reset to requester 1 so that requester 0 wins the first tie
  localparam req_id_t RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// rtl/add_arbiter_rr_pick.sv - combinational two-way round-robin picker
import add_arbiter_pkg::*;

module add_arbiter_rr_pick (
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    if (valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (valid[1]) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin sequencer sharing one adder; ADD_ARBITER_SATURATE_EN clamps overflowing sums
import add_arbiter_pkg::*;

module add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output req_id_t          rsp_id,
  input  logic             rsp_ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b;
  req_id_t          op_id;
  req_id_t          last_grant;
  logic             grant_valid;
  req_id_t          grant_id;
  logic             accept;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_out;

  add_arbiter_rr_pick u_pick (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Readies are gated by rst_n so nothing is accepted while reset is held
  assign accept     = rst_n && (state_q == IDLE) && grant_valid;
  assign req0_ready = accept && (grant_id == 1'b0);
  assign req1_ready = accept && (grant_id == 1'b1);

  assign sum_full = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADD_ARBITER_SATURATE_EN
  assign sum_out = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
  assign sum_out = sum_full[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      last_grant <= RESET_LAST_GRANT;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a       <= grant_id ? req1_a : req0_a;
        op_b       <= grant_id ? req1_b : req0_b;
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= sum_out;
        rsp_carry <= sum_full[WIDTH];
        rsp_id    <= op_id;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - randomized self-checking bench for add_arbiter against a transaction-level model
module tb_add_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
  logic         rsp_id;
  logic         rsp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // model: outstanding transaction, accept time, last winner, expected response
  bit           m_busy = 0;
  int           m_acc_cyc = 0;
  int           m_last = 1;
  logic [W-1:0] m_data;
  bit           m_carry;
  int           m_id;
  int           cyc = 0;
  int           last_win = -1;
  int           acc_ids[$];
  int           acc_cycs[$];

  add_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: compare outputs to the model, cross the edge, advance the model
  task automatic step();
    int win;
    int s;
    bit e_rv;
    logic [W-1:0] a, b;
    #1;
    win = -1;
    if (rst_n && !m_busy) begin
      if (req0_valid && req1_valid) win = 1 - m_last;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    e_rv = m_busy && (cyc >= m_acc_cyc + 2);
    check_eq("req0_ready", req0_ready, win == 0);
    check_eq("req1_ready", req1_ready, win == 1);
    check_eq("rsp_valid", rsp_valid, e_rv);
    if (e_rv) begin
      check_eq("rsp_data", rsp_data, m_data);
      check_eq("rsp_carry", rsp_carry, m_carry);
      check_eq("rsp_id", rsp_id, m_id);
    end
    a = (win == 1) ? req1_a : req0_a;
    b = (win == 1) ? req1_b : req0_b;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1;
      win    = -1;
    end else begin
      if (e_rv && rsp_ready) m_busy = 0;
      if (win >= 0) begin
        s         = int'(a) + int'(b);
        m_busy    = 1;
        m_acc_cyc = cyc;
        m_last    = win;
        m_id      = win;
        m_carry   = (s >= (1 << W));
        m_data    = s[W-1:0];
`ifdef ADD_ARBITER_SATURATE_EN
        if (m_carry) m_data = '1;
`endif
        acc_ids.push_back(win);
        acc_cycs.push_back(cyc);
      end
    end
    last_win = win;
    cyc++;
    #1;
  endtask

  // Requesters hold until accepted, then re-arm with probability p_new percent
  task automatic update_reqs(input int p_new);
    if (last_win == 0) req0_valid = 1'b0;
    if (last_win == 1) req1_valid = 1'b0;
    if (!req0_valid && $urandom_range(99) < p_new) begin
      req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom);
    end
    if (!req1_valid && $urandom_range(99) < p_new) begin
      req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_carry", rsp_carry, 0);
    check_eq("rst_rsp_id", rsp_id, 0);

    // first tie after reset: req0 single add, then req1 overflow
    req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h20;
    acc_ids.delete(); acc_cycs.delete();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) begin
        check_eq("add_data", rsp_data, 8'h46);
        check_eq("add_id", rsp_id, 0);
      end
      if (i == 5) begin
`ifdef ADD_ARBITER_SATURATE_EN
        check_eq("ovf_data", rsp_data, 8'hFF);
`else
        check_eq("ovf_data", rsp_data, 8'h10);
`endif
        check_eq("ovf_carry", rsp_carry, 1);
        check_eq("ovf_id", rsp_id, 1);
      end
      update_reqs(0);
    end
    check_eq("tie_count", acc_ids.size(), 2);
    if (acc_ids.size() == 2) begin
      check_eq("tie_first", acc_ids[0], 0);
      check_eq("tie_second", acc_ids[1], 1);
    end

    // fairness: both continuously valid, rsp_ready high
    acc_ids.delete(); acc_cycs.delete();
    for (int i = 0; i < 13; i++) begin
      update_reqs(100);
      step();
    end
    check_eq("fair_count", acc_ids.size(), 5);
    for (int i = 1; i < acc_ids.size(); i++) begin
      check_eq("fair_alt", acc_ids[i], 1 - acc_ids[i-1]);
      check_eq("fair_gap", acc_cycs[i] - acc_cycs[i-1], 3);
    end

    // backpressure: hold rsp_ready low for 5 cycles of rsp_valid
    rsp_ready = 1'b0;
    for (int i = 0; i < 10 && !(m_busy && cyc >= m_acc_cyc + 2); i++) begin
      update_reqs(100);
      step();
    end
    check_eq("bp_reached", m_busy && cyc >= m_acc_cyc + 2, 1);
    for (int i = 0; i < 5; i++) begin
      update_reqs(100);
      step();
    end
    rsp_ready = 1'b1;
    update_reqs(100);
    step();
    acc_ids.delete();
    update_reqs(100);
    step();
    check_eq("bp_release_accept", acc_ids.size(), 1);

    // reset while in EXEC
    for (int i = 0; i < 10 && !(m_busy && cyc == m_acc_cyc + 1); i++) begin
      update_reqs(100);
      step();
    end
    check_eq("exec_reached", m_busy && cyc == m_acc_cyc + 1, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_mid_rsp_valid", rsp_valid, 0);
      step();
    end

    // random traffic with random backpressure and occasional reset
    for (int i = 0; i < 400; i++) begin
      update_reqs(40);
      rsp_ready = ($urandom_range(99) < 60);
      rst_n = ($urandom_range(99) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
